// File: rtl/vga_timing_gen_if.sv
// Pixel-position bundle driven by the VGA timing generator and consumed by
// overlay/prompt controllers for ROM addressing and display blanking.
interface vga_timing_gen_if;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       bright;
  logic       hSync;
  logic       vSync;
  logic       pixel_tick;
  logic       line_start;
  logic       frame_start;

  modport master (
    output hCount, vCount, bright, hSync, vSync,
    output pixel_tick, line_start, frame_start
  );

  modport slave (
    input hCount, vCount, bright, hSync, vSync,
    input pixel_tick, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA scan timing: pixel-rate divider, horizontal/vertical counters,
// sync/visible decodes and registered line/frame start strobes.
module vga_timing_gen #(
  parameter int DIV         = 4,
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_SYNC      = 96,
  parameter int V_SYNC      = 2,
  parameter int H_VIS_START = 144,
  parameter int H_VIS_END   = 783,
  parameter int V_VIS_START = 35,
  parameter int V_VIS_END   = 514
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga
);
  localparam int DW = $clog2(DIV);

  logic [DW-1:0] divider_reg;
  logic [9:0]    h_count_reg;
  logic [9:0]    v_count_reg;
  logic          line_start_reg;
  logic          frame_start_reg;
  logic          tick;
  logic          h_last;
  logic          v_last;

  assign tick   = (divider_reg == DW'(DIV - 1));
  assign h_last = (h_count_reg == 10'(H_TOTAL - 1));
  assign v_last = (v_count_reg == 10'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      divider_reg     <= '0;
      h_count_reg     <= '0;
      v_count_reg     <= '0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      divider_reg     <= tick ? '0 : divider_reg + DW'(1);
      // Strobes are registered so they land on the first cycle of the new count.
      line_start_reg  <= tick && h_last;
      frame_start_reg <= tick && h_last && v_last;
      if (tick) begin
        if (!h_last) begin
          h_count_reg <= h_count_reg + 10'd1;
        end else begin
          h_count_reg <= '0;
          v_count_reg <= v_last ? '0 : v_count_reg + 10'd1;
        end
      end
    end
  end

  assign vga.hCount      = h_count_reg;
  assign vga.vCount      = v_count_reg;
  assign vga.pixel_tick  = tick;
  assign vga.line_start  = line_start_reg;
  assign vga.frame_start = frame_start_reg;
  assign vga.hSync       = !(h_count_reg < 10'(H_SYNC));
  assign vga.vSync       = !(v_count_reg < 10'(V_SYNC));
  assign vga.bright      = (h_count_reg >= 10'(H_VIS_START)) && (h_count_reg <= 10'(H_VIS_END)) &&
                           (v_count_reg >= 10'(V_VIS_START)) && (v_count_reg <= 10'(V_VIS_END));
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Producer side of the pixel-position interface consumed by every overlay/prompt controller in the VGA path.
- Divides the system clock into a pixel tick and runs the horizontal/vertical scan counters.
- Outputs hCount, vCount, bright, sync and frame/line strobes; controllers use these to address sprite ROMs and blank the display.
- Fixed 640x480@60 timing (800x525 total) from a 100 MHz clk.

Parameters:
- DIV, 4, system clocks per pixel; power of two, 2..16.
- H_TOTAL, 800, pixels per line, hCount range 0..H_TOTAL-1.
- V_TOTAL, 525, lines per frame, vCount range 0..V_TOTAL-1.
- H_SYNC, 96, hSync low while hCount < H_SYNC.
- V_SYNC, 2, vSync low while vCount < V_SYNC.
- H_VIS_START, 144, first visible hCount.
- H_VIS_END, 783, last visible hCount (inclusive).
- V_VIS_START, 35, first visible vCount.
- V_VIS_END, 514, last visible vCount (inclusive).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous, active-low reset.
- hCount  output  10  current horizontal pixel position.
- vCount  output  10  current line.
- bright  output  1  high inside the visible window.
- hSync  output  1  horizontal sync, active-low.
- vSync  output  1  vertical sync, active-low.
- pixel_tick  output  1  one-clk pulse: counters advance at the end of this cycle.
- line_start  output  1  one-clk pulse in the first clk cycle of hCount==0.
- frame_start  output  1  one-clk pulse in the first clk cycle of hCount==0 && vCount==0.

Behaviour:
- Reset: one clock, reset is synchronous and active-low. rst sampled low at a posedge sets:
  - divider=0, hCount=0, vCount=0, line_start=0, frame_start=0.
  - Decoded outputs therefore read hSync=0, vSync=0, bright=0, pixel_tick=0.
- Reset mid-frame aborts the scan with no partial strobe. The first frame after release begins at (0,0) with line_start/frame_start low for that first partial pixel.
- Divider: log2(DIV)-bit counter that increments every clk and wraps at DIV-1. pixel_tick = (divider==DIV-1), combinational from the register.
- Horizontal counter, on a clk edge with pixel_tick high:
  - hCount<H_TOTAL-1: hCount+1.
  - Otherwise: hCount=0 and vCount advances.
- Vertical counter: vCount<V_TOTAL-1 gives vCount+1; otherwise vCount=0. Wrap of both counters occurs on the same edge.
- Counters hold when pixel_tick is low. Each (hCount,vCount) value is stable for exactly DIV clk cycles.
- Decodes are combinational from the hCount/vCount registers, with zero latency relative to the counts:
  - hSync = !(hCount < H_SYNC)
  - vSync = !(vCount < V_SYNC)
  - bright = (H_VIS_START <= hCount <= H_VIS_END) && (V_VIS_START <= vCount <= V_VIS_END)
- Downstream controllers register one cycle of ROM latency. DIV>=2 keeps their pipelined window valid inside each pixel.
- line_start register: set to 1 on the edge where pixel_tick is high and hCount==H_TOTAL-1; cleared on every other edge.
- frame_start register: same rule, additionally requiring vCount==V_TOTAL-1.
- Both strobes coincide with the first clk cycle of the new count value.
- Arithmetic is unsigned 10-bit. Counts never reach H_TOTAL or V_TOTAL, so no overflow.
- Timing per line = H_TOTAL*DIV = 3200 clk. Timing per frame = 1,680,000 clk.

Test Plan:
- Reset release: hold rst=0 for 5 clk, then release -> hCount=0, vCount=0, hSync=0, vSync=0, bright=0. First pixel_tick appears 3 clk after release; hCount=1 one clk later.
- Line timing: run 3200 clk from reset release:
  - hSync low for the first 384 clk, then high.
  - hCount wraps 799->0 and vCount becomes 1 exactly 3200 clk after release.
  - line_start high for 1 clk at that point.
- Visible window:
  - bright first rises when hCount=144, vCount=35, i.e. clk (35*800+144)*4 = 112,576 after release.
  - bright falls when hCount becomes 784.
  - bright stays low for all of vCount=515..524.
- Frame wrap: run 1,680,000 clk -> vCount 524->0 and hCount 799->0 on the same edge. frame_start and line_start both high for exactly 1 clk. vSync is low for 6400 clk per frame.
- Mid-frame reset: at hCount=400, vCount=200 drive rst=0 for 1 clk -> next cycle counts are 0,0 and no frame_start pulse. The following frame_start occurs exactly 1,680,000 clk after release.
- Tick regularity: over 2 frames, pixel_tick period is always exactly 4 clk. hCount/vCount never exceed 799/524.
